ws2812_tx: RTL and testbench

//  Serialiser stage of the LED controller. Sits directly upstream of the pin

---
 rtl/ws2812_tx.sv | 162 ++++++++++++++++
 tb/tb_ws2812_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_tx.sv
// ws2812_tx: serialiser for a WS2812-style one-wire LED strip.
//
// Accepts 24-bit GRB pixels over a valid/ready handshake and emits the NRZ
// waveform, MSB first. Each bit lasts TBIT cycles; the line is high for T1H
// cycles on a '1' and T0H cycles on a '0'. After the pixel flagged as last,
// the line is held low for TRESET cycles and frame_done pulses.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   pix_data    24-bit pixel, bit 23 sent first
//   pix_valid   pix_data/pix_last valid
//   pix_last    pixel closes the frame
//   pix_ready   pixel accepted on this edge when pix_valid=1
//   dout        registered strip data line
//   busy        transmitter not idle
//   frame_done  one-cycle pulse after the latch period
//   underrun    one-cycle pulse when a non-last pixel ends with nothing queued
//
// State table:
//   IDLE  | line low, waiting for a pixel
//   SEND  | shifting out the 24 bits of the current pixel
//   LATCH | line held low for the strip latch time
module ws2812_tx #(
  parameter int T0H    = 8,
  parameter int T1H    = 16,
  parameter int TBIT   = 25,
  parameter int TRESET = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CW = $clog2(TBIT);
  localparam int LW = $clog2(TRESET + 1);

  localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT - 1);
  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [LW-1:0] TRES_M1 = LW'(TRESET - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t        state, state_nx;
  logic [23:0]   shreg, shreg_nx;
  logic          last_q, last_nx;
  logic [4:0]    bit_cnt, bit_nx;
  logic [CW-1:0] cyc_cnt, cyc_nx;
  logic [LW-1:0] lat_cnt, lat_nx;
  logic          dout_nx, done_nx, under_nx;

  logic          bit_end;
  logic          accept;
  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] th;

  assign bit_end   = (state == SEND) && (cyc_cnt == TBIT_M1);
  // Ready depends only on registered state so the source can never form a
  // combinational loop through pix_valid.
  assign pix_ready = !rst && ((state == IDLE) ||
                              (bit_end && (bit_cnt == 5'd0) && !last_q));
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state != IDLE);
  assign cyc_inc   = cyc_cnt + 1'b1;
  assign th        = shreg[23] ? T1H_C : T0H_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      last_q     <= 1'b0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      lat_cnt    <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      last_q     <= last_nx;
      bit_cnt    <= bit_nx;
      cyc_cnt    <= cyc_nx;
      lat_cnt    <= lat_nx;
      dout       <= dout_nx;
      frame_done <= done_nx;
      underrun   <= under_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    last_nx  = last_q;
    bit_nx   = bit_cnt;
    cyc_nx   = cyc_cnt;
    lat_nx   = lat_cnt;
    dout_nx  = 1'b0;
    done_nx  = 1'b0;
    under_nx = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SEND;
          shreg_nx = pix_data;
          last_nx  = pix_last;
          bit_nx   = 5'd23;
          cyc_nx   = '0;
          dout_nx  = 1'b1;
        end
      end

      SEND: begin
        if (!bit_end) begin
          // dout is registered, so it is computed for the cycle being entered.
          cyc_nx  = cyc_inc;
          dout_nx = (cyc_inc < th);
        end else if (bit_cnt != 5'd0) begin
          shreg_nx = {shreg[22:0], 1'b0};
          bit_nx   = bit_cnt - 5'd1;
          cyc_nx   = '0;
          dout_nx  = 1'b1;
        end else if (last_q) begin
          state_nx = LATCH;
          cyc_nx   = '0;
          lat_nx   = '0;
        end else if (accept) begin
          shreg_nx = pix_data;
          last_nx  = pix_last;
          bit_nx   = 5'd23;
          cyc_nx   = '0;
          dout_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
          cyc_nx   = '0;
          under_nx = 1'b1;
        end
      end

      LATCH: begin
        if (lat_cnt == TRES_M1) begin
          state_nx = IDLE;
          lat_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          lat_nx = lat_cnt + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: self-checking bench for ws2812_tx.
//
// The driver pushes the expected bit sequence of every accepted pixel into a
// queue; an independent monitor decodes dout from its high/low run lengths
// and pops the queue. Latch length, underrun spacing and pulse counts are
// checked from the waveform as well.
module tb_ws2812_tx;

  localparam int T0H    = 8;
  localparam int T1H    = 16;
  localparam int TBIT   = 25;
  localparam int TRESET = 1000;
  localparam int TPIX   = 24 * TBIT;

  typedef struct {
    bit val;
    bit cont;   // next bit follows with no gap
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        pix_ready, dout, busy, frame_done, underrun;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_fd = 0, obs_fd = 0;
  int   exp_ur = 0, obs_ur = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   ready_cnt = 0;
  bit   ready_cnt_en = 0;

  ws2812_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready), .dout(dout), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit dprev = 0, pcont = 0;
  int hcnt = 0, low_run = 0, ph = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      dprev = 0; pcont = 0; hcnt = 0; low_run = 0; ph = 0;
    end else begin
      if (dout) begin
        if (!dprev) begin
          if (pcont) chk("bit_period", low_run + ph, TBIT);
          hcnt = 1;
        end else begin
          hcnt++;
        end
        low_run = 0;
      end else begin
        if (dprev) begin
          chk("high_time_legal", int'(hcnt == T0H || hcnt == T1H), 1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bit: got high time %0d expected no bit", hcnt);
          end else begin
            e = exp_q.pop_front();
            chk("bit_value", int'(hcnt == T1H), int'(e.val));
            pcont = e.cont;
          end
          ph = hcnt;
          low_run = 1;
        end else begin
          low_run++;
        end
      end
      dprev = dout;
      if (frame_done) begin
        obs_fd++;
        chk("latch_low_time", low_run, TBIT - ph + TRESET + 1);
      end
      if (underrun) begin
        obs_ur++;
        chk("underrun_gap", low_run, TBIT - ph + 1);
      end
      if (frame_done && underrun) chk("done_underrun_exclusive", 1, 0);
    end
  end

  always @(negedge clk)
    if (ready_cnt_en && pix_ready && !frame_done) ready_cnt++;

  // ---------------- driver ----------------
  task automatic push_pixel(input logic [23:0] d, input logic l, input bit nc);
    for (int b = 23; b >= 0; b--) begin
      exp_t e;
      e.val  = d[b];
      e.cont = (b != 0) ? 1'b1 : nc;
      exp_q.push_back(e);
    end
    if (l) exp_fd++;
    else if (!nc) exp_ur++;
  endtask

  // nc: the following pixel is expected to start without a gap
  task automatic send_pixel(input logic [23:0] d, input logic l, input bit nc);
    int w = 0;
    @(negedge clk);
    pix_data = d; pix_last = l; pix_valid = 1'b1;
    while (!pix_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!pix_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      push_pixel(d, l, nc);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(output int dt, output int busy_low);
    int n = 0;
    busy_low = 0;
    dt = -1;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (frame_done) begin
        dt = cyc - acc_cyc;
        break;
      end
      if (!busy) busy_low++;
    end
    if (dt < 0) chk("frame_done_timeout", 0, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt, bl, w, n;
    logic [23:0] v;
    bit big[8];

    // reset state
    rst = 1'b1;
    #2;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", pix_ready, 1);

    // 1: single pixel, latch and frame_done timing
    send_pixel(24'hFF0000, 1'b1, 1'b0);
    wait_done(dt, bl);
    chk("t1_done_cycle", dt, TPIX + TRESET);
    chk("t1_busy_low", bl, 0);

    // 2: three pixels back to back
    send_pixel(24'h123456, 1'b0, 1'b1);
    n = acc_cyc;
    ready_cnt = 0;
    ready_cnt_en = 1;
    send_pixel(24'hABCDEF, 1'b0, 1'b1);
    send_pixel(24'h000001, 1'b1, 1'b0);
    acc_cyc = n;
    wait_done(dt, bl);
    ready_cnt_en = 0;
    chk("t2_done_cycle", dt, 3 * TPIX + TRESET);
    chk("t2_ready_pulses", ready_cnt, 2);
    chk("t2_busy_low", bl, 0);

    // 3: underrun then restart
    send_pixel(24'hA5A5A5, 1'b0, 1'b0);
    repeat (TPIX + 20) @(negedge clk);
    chk("t3_dout_idle", dout, 0);
    chk("t3_ready_idle", pix_ready, 1);
    chk("t3_busy_idle", busy, 0);
    send_pixel(24'h5A5A5A, 1'b1, 1'b0);
    wait_done(dt, bl);
    chk("t3_done_cycle", dt, TPIX + TRESET);

    // 4: asynchronous reset in the high phase of bit 10
    send_pixel(24'hFFFFFF, 1'b1, 1'b0);
    repeat ((23 - 10) * TBIT + 4) @(posedge clk);
    #1;
    chk("t4_dout_before_rst", dout, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_dout", dout, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", pix_ready, 0);
    exp_q.delete();
    exp_fd--;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_pixel(24'h00FF00, 1'b1, 1'b0);
    wait_done(dt, bl);
    chk("t4_done_cycle", dt, TPIX + TRESET);

    // 5: valid held with changing data through the latch period
    send_pixel(24'h0F0F0F, 1'b1, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      v = 24'($urandom);
      pix_data = v; pix_last = 1'b1; pix_valid = 1'b1;
      w++;
    end while (!pix_ready && w < 5000);
    chk("t5_ready_rise_cycle", w, TPIX + TRESET + 1);
    chk("t5_ready_with_done", frame_done, 1);
    push_pixel(v, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    pix_valid = 1'b0;
    pix_data = 24'($urandom);
    wait_done(dt, bl);
    chk("t5_done_cycle", dt, TPIX + TRESET);

    // 6: random frames with random gaps, occasional underruns
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) big[i] = (i > 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
        if (i > 0) repeat (big[i] ? TPIX + 20 : $urandom_range(0, 4)) @(negedge clk);
        send_pixel(24'($urandom), i == n - 1,
                   (i < n - 1) && !big[(i < 7) ? i + 1 : 7]);
      end
      wait_done(dt, bl);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_done_count", obs_fd, exp_fd);
    chk("underrun_count", obs_ur, exp_ur);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
